// File: rtl/cntr8_seq.sv
// rtl/cntr8_seq.sv - command sequencer driving an external 8-bit load/inc counter
module cntr8_seq #(
    parameter logic [7:0] RST_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_arg,
    input  logic       abort,
    output logic       cmd_ready,
    output logic       load,
    output logic       inc,
    output logic [7:0] d_out,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_UP   = 3'd2,
        ST_DOWN = 3'd3,
        ST_ACK  = 3'd4
    } state_t;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_INC  = 2'b10;
    localparam logic [1:0] OP_DEC  = 2'b11;

    state_t     state_q, state_d;
    logic [7:0] shadow_q, shadow_d;
    logic [7:0] rem_q, rem_d;

    logic       load_q, load_d;
    logic       inc_q, inc_d;
    logic [7:0] d_out_q, d_out_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       cmd_ready_q, cmd_ready_d;

    // Next-state, shadow count and remaining-step bookkeeping
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        rem_d    = rem_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_NOP: state_d = ST_ACK;
                        OP_LOAD: begin
                            state_d  = ST_LOAD;
                            shadow_d = cmd_arg;
                        end
                        OP_INC, OP_DEC: begin
                            if (cmd_arg == 8'h00) begin
                                state_d = ST_ACK;
                            end else begin
                                rem_d   = cmd_arg;
                                state_d = (cmd_op == OP_INC) ? ST_UP : ST_DOWN;
                            end
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
            end
            ST_LOAD: state_d = ST_ACK;
            ST_UP, ST_DOWN: begin
                if (abort) begin
                    state_d = ST_ACK;
                end else begin
                    shadow_d = (state_q == ST_UP) ? shadow_q + 8'd1 : shadow_q - 8'd1;
                    rem_d    = rem_q - 8'd1;
                    if (rem_q == 8'd1) begin
                        state_d = ST_ACK;
                    end
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode of the upcoming state so the outputs leave a flop each cycle
    always_comb begin
        load_d      = 1'b1;
        inc_d       = 1'b0;
        d_out_d     = shadow_d;
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_ACK);
        cmd_ready_d = (state_d == ST_IDLE);
        case (state_d)
            ST_UP: begin
                load_d = 1'b0;
                inc_d  = 1'b1;
            end
            ST_DOWN: begin
                load_d = 1'b0;
                inc_d  = 1'b0;
            end
            default: begin
                load_d = 1'b1;
                inc_d  = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs; reset overrides any command in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            shadow_q    <= RST_VAL;
            rem_q       <= 8'h00;
            load_q      <= 1'b1;
            inc_q       <= 1'b0;
            d_out_q     <= RST_VAL;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            rem_q       <= rem_d;
            load_q      <= load_d;
            inc_q       <= inc_d;
            d_out_q     <= d_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    assign load      = load_q;
    assign inc       = inc_q;
    assign d_out     = d_out_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign cmd_ready = cmd_ready_q;

endmodule

// File: tb/tb_cntr8_seq.sv
// tb/tb_cntr8_seq.sv - directed self-checking bench for cntr8_seq
module tb_cntr8_seq;

    localparam logic [7:0] RV = 8'hA5;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic [7:0] cmd_arg;
    logic       abort;
    logic       cmd_ready;
    logic       load;
    logic       inc;
    logic [7:0] d_out;
    logic       busy;
    logic       done;

    int n_total = 0;
    int n_bad   = 0;

    cntr8_seq #(.RST_VAL(RV)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_op    (cmd_op),
        .cmd_arg   (cmd_arg),
        .abort     (abort),
        .cmd_ready (cmd_ready),
        .load      (load),
        .inc       (inc),
        .d_out     (d_out),
        .busy      (busy),
        .done      (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic ld, input logic in,
                              input logic [7:0] d, input logic dn, input logic bsy);
        check({tag, ".load"},  {31'd0, load},  {31'd0, ld});
        check({tag, ".inc"},   {31'd0, inc},   {31'd0, in});
        check({tag, ".d_out"}, {24'd0, d_out}, {24'd0, d});
        check({tag, ".done"},  {31'd0, done},  {31'd0, dn});
        check({tag, ".busy"},  {31'd0, busy},  {31'd0, bsy});
        check({tag, ".ready"}, {31'd0, cmd_ready}, {31'd0, ~bsy});
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present a command in IDLE, let it be accepted, and return in the cycle after acceptance
    task automatic issue(input logic [1:0] op, input logic [7:0] arg);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_arg   = 8'h00;
        abort     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        expect_out("reset", 1'b1, 1'b0, RV, 1'b0, 1'b0);
        reset = 1'b0;
        tick();
        expect_out("idle", 1'b1, 1'b0, RV, 1'b0, 1'b0);

        // LOAD 5A
        issue(2'b01, 8'h5A);
        expect_out("ld5a.t1", 1'b1, 1'b0, 8'h5A, 1'b0, 1'b1);
        tick();
        expect_out("ld5a.t2", 1'b1, 1'b0, 8'h5A, 1'b1, 1'b1);
        tick();
        expect_out("ld5a.t3", 1'b1, 1'b0, 8'h5A, 1'b0, 1'b0);

        // LOAD FD then INC 4 wrapping through 00
        issue(2'b01, 8'hFD);
        tick();
        tick();
        issue(2'b10, 8'd4);
        begin
            logic [7:0] up_seq [4];
            up_seq = '{8'hFD, 8'hFE, 8'hFF, 8'h00};
            for (int i = 0; i < 4; i++) begin
                expect_out($sformatf("inc4.s%0d", i), 1'b0, 1'b1, up_seq[i], 1'b0, 1'b1);
                tick();
            end
        end
        expect_out("inc4.done", 1'b1, 1'b0, 8'h01, 1'b1, 1'b1);
        tick();
        expect_out("inc4.idle", 1'b1, 1'b0, 8'h01, 1'b0, 1'b0);

        // LOAD 01 then DEC 3 wrapping through FF
        issue(2'b01, 8'h01);
        tick();
        tick();
        issue(2'b11, 8'd3);
        begin
            logic [7:0] dn_seq [3];
            dn_seq = '{8'h01, 8'h00, 8'hFF};
            for (int i = 0; i < 3; i++) begin
                expect_out($sformatf("dec3.s%0d", i), 1'b0, 1'b0, dn_seq[i], 1'b0, 1'b1);
                tick();
            end
        end
        expect_out("dec3.done", 1'b1, 1'b0, 8'hFE, 1'b1, 1'b1);
        tick();
        expect_out("dec3.idle", 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0);

        // INC 0 and NOP complete immediately without stepping
        issue(2'b10, 8'd0);
        expect_out("inc0.done", 1'b1, 1'b0, 8'hFE, 1'b1, 1'b1);
        tick();
        expect_out("inc0.idle", 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0);
        issue(2'b00, 8'h77);
        expect_out("nop.done", 1'b1, 1'b0, 8'hFE, 1'b1, 1'b1);
        tick();
        expect_out("nop.idle", 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0);

        // Abort in IDLE has no effect
        abort = 1'b1;
        tick();
        expect_out("abort.idle", 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0);
        abort = 1'b0;

        // INC 10 aborted in its 4th UP cycle: three increments FE->01
        issue(2'b10, 8'd10);
        expect_out("abt.s0", 1'b0, 1'b1, 8'hFE, 1'b0, 1'b1);
        tick();
        expect_out("abt.s1", 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1);
        tick();
        expect_out("abt.s2", 1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
        tick();
        expect_out("abt.s3", 1'b0, 1'b1, 8'h01, 1'b0, 1'b1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        expect_out("abt.done", 1'b1, 1'b0, 8'h01, 1'b1, 1'b1);
        tick();
        expect_out("abt.idle", 1'b1, 1'b0, 8'h01, 1'b0, 1'b0);

        // DEC 5 with a held LOAD request and reset at step 2
        issue(2'b11, 8'd5);
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_arg   = 8'h33;
        expect_out("rst.s0", 1'b0, 1'b0, 8'h01, 1'b0, 1'b1);
        tick();
        expect_out("rst.s1", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        reset = 1'b1;
        tick();
        expect_out("rst.after", 1'b1, 1'b0, RV, 1'b0, 1'b0);
        reset = 1'b0;
        tick();
        cmd_valid = 1'b0;
        expect_out("held.ld", 1'b1, 1'b0, 8'h33, 1'b0, 1'b1);
        tick();
        expect_out("held.done", 1'b1, 1'b0, 8'h33, 1'b1, 1'b1);
        tick();
        expect_out("held.idle", 1'b1, 1'b0, 8'h33, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/cntr8_seq.md
CNTR8_SEQ -- requirements
Module: cntr8_seq

Interface
REQ-001 The module SHALL have one parameter: RST_VAL, default 8'h00, giving the shadow count value after reset.
REQ-002 clk  input  1  rising-edge clock; all state updates on this edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 cmd_valid  input  1  command request.
REQ-005 cmd_op  input  2  operation code: 00 NOP, 01 LOAD, 10 INC, 11 DEC.
REQ-006 cmd_arg  input  8  load value (LOAD) or step count N (INC/DEC); ignored for NOP.
REQ-007 abort  input  1  ends an in-progress INC/DEC early.
REQ-008 cmd_ready  output  1  command accept strobe; high only in IDLE.
REQ-009 load  output  1  counter load control, driven to the cntr8 load input.
REQ-010 inc  output  1  counter direction control, driven to the cntr8 inc input.
REQ-011 d_out  output  8  counter load data.
REQ-012 busy  output  1  high when the state is not IDLE.
REQ-013 done  output  1  one-cycle command-completion pulse.

Function
REQ-014 The module SHALL be a Moore FSM with states IDLE, LOAD, UP, DOWN and ACK, plus an 8-bit shadow count and an 8-bit remaining-step counter rem.
REQ-015 A command SHALL be accepted only on a clock edge where cmd_valid=1 and cmd_ready=1.
REQ-016 cmd_ready SHALL equal (state==IDLE).
REQ-017 cmd_valid while not in IDLE SHALL be ignored; the requester holds the command until it is accepted.
REQ-018 Output decode: IDLE, LOAD and ACK SHALL drive load=1, inc=0, d_out=shadow (the counter is held by reloading the shadow count, because the counter always counts when load=0).
REQ-019 Output decode: UP SHALL drive load=0, inc=1; DOWN SHALL drive load=0, inc=0; in both states d_out=shadow.
REQ-020 Accept of NOP SHALL transition IDLE->ACK with no change to shadow.
REQ-021 Accept of LOAD SHALL transition IDLE->LOAD and set shadow<=cmd_arg; LOAD SHALL always go to ACK on the next edge.
REQ-022 Accept of INC/DEC with N=cmd_arg!=0 SHALL set rem<=N and go to UP (INC) or DOWN (DEC).
REQ-023 Accept of INC/DEC with N=0 SHALL go directly to ACK with no step cycles.
REQ-024 At each edge in UP, shadow SHALL take shadow+1 mod 256 (8'hFF->8'h00) and rem SHALL take rem-1.
REQ-025 At each edge in DOWN, shadow SHALL take shadow-1 mod 256 (8'h00->8'hFF) and rem SHALL take rem-1.
REQ-026 In UP/DOWN, when rem==1 the state SHALL go to ACK on the edge that performs that final step, so exactly N step cycles occur.
REQ-027 When abort=1 in UP/DOWN, the state SHALL go to ACK on that edge, with no shadow or rem update for that cycle; abort outside UP/DOWN SHALL have no effect.
REQ-028 ACK SHALL drive done=1 and SHALL always go to IDLE on the next edge; done SHALL be 0 in all other states.
REQ-029 busy SHALL equal (state!=IDLE).
REQ-030 Latency from the accept edge T: LOAD gives LOAD at T+1, done at T+2, ready at T+3; INC/DEC gives steps T+1..T+N, done at T+N+1, ready at T+N+2; NOP and N=0 give done at T+1, ready at T+2.
REQ-031 The shadow count SHALL equal the attached counter's value whenever a step model of ±1 per UP/DOWN cycle holds.
REQ-032 The state encoding SHALL be fully specified; unused codes SHALL return to IDLE with no output glitch beyond that cycle's decode.

Reset
REQ-033 On a clock edge with reset=1, the module SHALL set state=IDLE, shadow=RST_VAL and rem=0, overriding any command, abort or step in progress.
REQ-034 After reset the outputs SHALL be load=1, inc=0, d_out=RST_VAL, done=0, busy=0 and cmd_ready=1.
REQ-035 Reset mid-command SHALL produce no done pulse for the aborted command.

Verification
REQ-036 Reset, then LOAD 8'h5A -> d_out=8'h5A with load=1 from T+1; done at T+2; cmd_ready at T+3.
REQ-037 LOAD 8'hFD, then INC 4 -> inc=1 and load=0 for 4 cycles; shadow sequence FE, FF, 00, 01; done with d_out=8'h01.
REQ-038 LOAD 8'h01, then DEC 3 -> 3 DOWN cycles; d_out=8'hFE at done.
REQ-039 INC 0 and NOP each -> done at T+1, no inc pulse, d_out unchanged.
REQ-040 INC 10 with abort asserted in the 4th UP cycle -> exactly 3 increments, done on the next cycle, ready afterwards.
REQ-041 reset asserted during DEC 5 at step 2 -> state IDLE and d_out=RST_VAL next cycle, no done; cmd_valid held during busy is not accepted until IDLE.
